// File: rtl/cram_loader.sv
// cram_loader: merges Z80 byte-pair writes and DMA bursts into the CRAM write port
module cram_loader #(
    parameter int MAXLEN = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_wr,
    input  logic        cpu_hi,
    input  logic [7:0]  cpu_idx,
    input  logic [7:0]  cpu_data,
    input  logic        dma_start,
    input  logic [7:0]  dma_idx,
    input  logic [7:0]  dma_len,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [7:0]  cram_addr,
    output logic [15:0] cram_data,
    output logic        cram_we,
    output logic        dma_busy,
    output logic        dma_done
);
    localparam int CW = $clog2(MAXLEN);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

    state_t        state, state_nx;
    logic [7:0]    addr;
    logic [CW-1:0] count;
    logic [15:0]   pend;
    logic [7:0]    lat;
    logic          commit, start_ok, dma_wr;

    assign commit   = cpu_wr & cpu_hi;
    assign start_ok = dma_start & ((state == IDLE) | (state == DONE));
    assign dma_wr   = (state == WRITE) & ~commit;

    // next-state and state-decoded outputs; a CPU commit holds the DMA in WRITE
    always_comb begin
        state_nx = state;
        mem_req  = state == REQ;
        dma_busy = (state == REQ) | (state == WRITE);
        dma_done = state == DONE;
        case (state)
            IDLE, DONE: state_nx = dma_start ? REQ : IDLE;
            REQ:        state_nx = mem_ack ? WRITE : REQ;
            WRITE:      state_nx = commit ? WRITE : (count == '0 ? DONE : REQ);
            default:    state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // burst address/count, pending word, low-byte latch and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            count     <= '0;
            pend      <= '0;
            lat       <= '0;
            cram_we   <= 1'b0;
            cram_addr <= '0;
            cram_data <= '0;
        end else begin
            if (start_ok) begin
                addr  <= dma_idx;
                count <= CW'(dma_len);
            end
            if (state == REQ && mem_ack) pend <= mem_data;
            if (dma_wr && count != '0) begin
                count <= count - CW'(1);
                addr  <= addr + 8'd1;
            end
            if (cpu_wr && !cpu_hi) lat <= cpu_data;
            cram_we   <= commit | (state == WRITE);
            cram_addr <= commit ? cpu_idx : (dma_wr ? addr : cram_addr);
            cram_data <= commit ? {cpu_data, lat} : (dma_wr ? pend : cram_data);
        end
    end
endmodule

// File: doc/cram_loader.md
Name: cram_loader

Overview:
- Write-side engine for the 256x16 colour RAM (CRAM) palette.
- Merges two sources into the single CRAM write port:
  - Z80 byte writes, paired into 16-bit entries.
  - A DMA burst that copies 16-bit words from system memory into consecutive CRAM entries.
- Sits between the Z80 port decoder / DMA arbiter and the palette RAM write port (cram_addr, cram_data, cram_we).

Parameters:
- MAXLEN, 256, maximum DMA burst length in words; dma_len encodes 1..MAXLEN as value+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_wr  in  1  one-cycle Z80 CRAM write strobe.
- cpu_hi  in  1  byte select: 0 = low byte (latch only), 1 = high byte (commit).
- cpu_idx  in  8  CRAM entry index for a CPU write.
- cpu_data  in  8  CPU write byte.
- dma_start  in  1  one-cycle burst start pulse.
- dma_idx  in  8  first CRAM entry of the burst.
- dma_len  in  8  burst length minus 1 (0 = 1 word, 255 = 256 words).
- mem_req  out  1  memory read request, held until mem_ack.
- mem_ack  in  1  one-cycle acknowledge; mem_data is valid in the same cycle.
- mem_data  in  16  memory read word.
- cram_addr  out  8  CRAM write address (registered).
- cram_data  out  16  CRAM write data (registered); bit 15 = DAC mode, bits 14:0 = RGB555.
- cram_we  out  1  CRAM write enable (registered, one cycle per word).
- dma_busy  out  1  high from the cycle after dma_start until the final write is issued.
- dma_done  out  1  one-cycle pulse in the cycle after the final DMA write.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM goes to IDLE; low-byte latch = 0, word counter = 0, pending-DMA-word flag = 0.
- CPU path:
  - cpu_wr with cpu_hi=0 stores cpu_data in the low-byte latch. No CRAM write.
  - cpu_wr with cpu_hi=1 at cycle N gives cram_we=1 at N+1, cram_addr=cpu_idx, cram_data={cpu_data, latch}.
  - The latch keeps its value after a commit. A high-byte write with no preceding low write uses the stale latch.
- FSM states: IDLE, REQ, WRITE, DONE.
  - IDLE: dma_start → REQ. Load addr=dma_idx and count=dma_len. Set dma_busy.
  - REQ: mem_req=1, held until mem_ack. On mem_ack, capture mem_data in the pending word, drop mem_req next cycle, go to WRITE.
  - WRITE: issue the CRAM write of the pending word at addr, unless a CPU commit claims the port this cycle.
    - If count==0 → DONE.
    - Otherwise decrement count, increment addr (8-bit wrap: 255 → 0), → REQ.
  - DONE: pulse dma_done, clear dma_busy, → IDLE.
- Write-port arbitration: a CPU commit beats a DMA write in the same cycle.
  - The DMA stays in WRITE with its word held, and writes on the next cycle with no CPU commit.
  - No write is ever dropped.
- dma_start while dma_busy=1 is ignored; the burst in progress is unaffected.
- dma_start and a CPU commit in the same cycle: both are accepted. CPU write at N+1; the DMA starts normally.
- Minimum per-word DMA time with immediate ack: REQ(ack) → WRITE = 2 cycles per word. A 1-word burst makes dma_done 3 cycles after the start pulse.
- mem_ack outside REQ is ignored.
- Reset mid-burst: aborts immediately.
  - mem_req and cram_we drop asynchronously.
  - No dma_done pulse.
  - Any partially written CRAM content remains.

Test Plan:
- CPU pair: low write 0x1F to idx 0x05, then high write 0x80 → cram_we one cycle later, addr=0x05, data=0x801F; exactly one write.
- DMA 4-word burst, dma_idx=0xFE, dma_len=3, ack one cycle after each req, data 0x1111..0x4444 → writes at 0xFE, 0xFF, 0x00, 0x01 in order; dma_done pulses once; dma_busy falls with it.
- Collision: CPU commit (idx 0x10, data 0x7FFF) in the same cycle the DMA is in WRITE for idx 0x20 → 0x10 written first, 0x20 written the next cycle; both values present in the CRAM model.
- Re-start while busy: second dma_start mid-burst with a different dma_idx → ignored; the original burst completes with the original addresses and count.
- Async reset: drop rst_n while mem_req=1 in a 256-word burst → mem_req, cram_we, dma_busy are 0 without a clock edge; no dma_done; a new burst after reset runs correctly.
- Max burst: dma_len=255 from idx 0x00 with randomised ack delays (0..5 cycles) → exactly 256 writes covering all indices once; data matches the memory model.
